display_fx_sequencer: RTL and testbench

Frame-synchronous controller that sequences the video layer mux through the game's display phases: title, play, post-hit blink, fade-out and game-over. It sits beside the object mux, drives a per-layer enable mask and a fade level the mux applies, and changes state only on frame boundaries so no frame tears mid-scan.

---
 rtl/display_fx_sequencer_if.sv | 22 ++
 rtl/display_fx_sequencer.sv | 177 +++++++++++++++++
 tb/tb_display_fx_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_fx_sequencer_if.sv
// Event pulses into, and layer-mux controls out of, the display fx sequencer.
// The slave side is the sequencer; the master side is the game logic / video mux.
interface display_fx_sequencer_if;
    logic       startOfFrame;
    logic       gameStart;
    logic       playerHit;
    logic       gameOver;
    logic [7:0] layerEn;
    logic [2:0] fadeLevel;
    logic       hitInvuln;
    logic [2:0] fxState;

    modport master (
        output startOfFrame, gameStart, playerHit, gameOver,
        input  layerEn, fadeLevel, hitInvuln, fxState
    );

    modport slave (
        input  startOfFrame, gameStart, playerHit, gameOver,
        output layerEn, fadeLevel, hitInvuln, fxState
    );
endinterface

// File: rtl/display_fx_sequencer.sv
// Frame-synchronous display phase sequencer driving the layer mask and fade level.
// Latency: 1 clk from the SOF that evaluates an event; no backpressure, events latch until the next SOF.
module display_fx_sequencer #(
    parameter int BLINK_FRAMES     = 48,
    parameter int BLINK_HALF       = 4,
    parameter int FADE_STEP_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    display_fx_sequencer_if.slave bus
);
    localparam int MAXP = (BLINK_FRAMES > BLINK_HALF)
                        ? ((BLINK_FRAMES > FADE_STEP_FRAMES) ? BLINK_FRAMES : FADE_STEP_FRAMES)
                        : ((BLINK_HALF > FADE_STEP_FRAMES) ? BLINK_HALF : FADE_STEP_FRAMES);
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(BLINK_HALF - 1);
    localparam logic [CW-1:0] STEP_LAST  = CW'(FADE_STEP_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_TITLE = 3'd0,
        ST_PLAY  = 3'd1,
        ST_BLINK = 3'd2,
        ST_FADE  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [CW-1:0] half_cnt_q, half_cnt_d;
    logic          half_phase_q, half_phase_d;
    logic [CW-1:0] step_cnt_q, step_cnt_d;
    logic [2:0]    fade_q, fade_d;
    logic          pend_start_q, pend_start_d;
    logic          pend_hit_q, pend_hit_d;
    logic          pend_over_q, pend_over_d;

    logic [7:0]    layer_en_q, layer_en_d;
    logic [2:0]    fade_level_q, fade_level_d;
    logic          hit_invuln_q, hit_invuln_d;
    logic [2:0]    fx_state_q, fx_state_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_TITLE;
            frame_cnt_q  <= '0;
            half_cnt_q   <= '0;
            half_phase_q <= 1'b0;
            step_cnt_q   <= '0;
            fade_q       <= 3'd0;
            pend_start_q <= 1'b0;
            pend_hit_q   <= 1'b0;
            pend_over_q  <= 1'b0;
            layer_en_q   <= 8'h81;
            fade_level_q <= 3'd0;
            hit_invuln_q <= 1'b0;
            fx_state_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            half_cnt_q   <= half_cnt_d;
            half_phase_q <= half_phase_d;
            step_cnt_q   <= step_cnt_d;
            fade_q       <= fade_d;
            pend_start_q <= pend_start_d;
            pend_hit_q   <= pend_hit_d;
            pend_over_q  <= pend_over_d;
            layer_en_q   <= layer_en_d;
            fade_level_q <= fade_level_d;
            hit_invuln_q <= hit_invuln_d;
            fx_state_q   <= fx_state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        half_cnt_d   = half_cnt_q;
        half_phase_d = half_phase_q;
        step_cnt_d   = step_cnt_q;
        fade_d       = fade_q;
        pend_start_d = pend_start_q | bus.gameStart;
        pend_hit_d   = pend_hit_q   | bus.playerHit;
        pend_over_d  = pend_over_q  | bus.gameOver;
        layer_en_d   = 8'h81;
        fade_level_d = 3'd0;
        hit_invuln_d = 1'b0;
        fx_state_d   = 3'd0;

        if (bus.startOfFrame) begin
            // Flags evaluated now are discarded; a pulse landing on this SOF waits for the next one.
            pend_start_d = bus.gameStart;
            pend_hit_d   = bus.playerHit;
            pend_over_d  = bus.gameOver;

            case (state_q)
                ST_TITLE: begin
                    if (pend_start_q) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (pend_over_q) begin
                        state_d    = ST_FADE;
                        fade_d     = 3'd0;
                        step_cnt_d = '0;
                    end else if (pend_hit_q) begin
                        state_d      = ST_BLINK;
                        frame_cnt_d  = '0;
                        half_cnt_d   = '0;
                        half_phase_d = 1'b0;
                    end
                end
                ST_BLINK: begin
                    if (pend_over_q) begin
                        state_d    = ST_FADE;
                        fade_d     = 3'd0;
                        step_cnt_d = '0;
                    end else if (frame_cnt_q == BLINK_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        if (half_cnt_q == HALF_LAST) begin
                            half_cnt_d   = '0;
                            half_phase_d = ~half_phase_q;
                        end else begin
                            half_cnt_d = half_cnt_q + 1'b1;
                        end
                    end
                end
                ST_FADE: begin
                    if (step_cnt_q == STEP_LAST) begin
                        if (fade_q == 3'd7) begin
                            state_d = ST_OVER;
                        end else begin
                            step_cnt_d = '0;
                            fade_d     = fade_q + 3'd1;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                ST_OVER: begin
                    if (pend_start_q) begin
                        state_d = ST_TITLE;
                    end
                end
                default: begin
                    state_d = ST_TITLE;
                end
            endcase
        end

        // Outputs are decoded from next state so they register on the same edge as the SOF.
        fx_state_d = state_d;
        case (state_d)
            ST_PLAY:  layer_en_d = 8'hFF;
            ST_BLINK: begin
                layer_en_d    = {1'b1, half_phase_d, 6'h3F};
                hit_invuln_d  = 1'b1;
            end
            ST_FADE: begin
                layer_en_d   = 8'hFF;
                fade_level_d = fade_d;
            end
            ST_OVER:  layer_en_d = 8'h80;
            default:  layer_en_d = 8'h81;
        endcase
    end

    assign bus.layerEn   = layer_en_q;
    assign bus.fadeLevel = fade_level_q;
    assign bus.hitInvuln = hit_invuln_q;
    assign bus.fxState   = fx_state_q;

endmodule

// File: tb/tb_display_fx_sequencer.sv
// Bench for display_fx_sequencer: directed scenarios plus randomized event traffic
// checked against a frames-since-entry reference model.
module tb_display_fx_sequencer;
    localparam int BF = 48;
    localparam int BH = 4;
    localparam int FS = 4;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    display_fx_sequencer_if bus();

    display_fx_sequencer #(
        .BLINK_FRAMES    (BF),
        .BLINK_HALF      (BH),
        .FADE_STEP_FRAMES(FS)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase number and count of SOFs since the phase was entered.
    int m_state;
    int m_k;
    bit m_ps, m_ph, m_po;

    localparam logic [14:0] RESET_OUT = {3'd0, 8'h81, 3'd0, 1'b0};

    function automatic logic [14:0] exp_out();
        logic [7:0] le;
        logic [2:0] fl;
        logic       inv;
        le = 8'h81; fl = 3'd0; inv = 1'b0;
        case (m_state)
            1: le = 8'hFF;
            2: begin le = 8'hFF; le[6] = ((m_k / BH) % 2) == 1; inv = 1'b1; end
            3: begin le = 8'hFF; fl = 3'(m_k / FS); end
            4: le = 8'h80;
            default: le = 8'h81;
        endcase
        return {3'(m_state), le, fl, inv};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.fxState, bus.layerEn, bus.fadeLevel, bus.hitInvuln};
    endfunction

    task automatic model_reset();
        m_state = 0; m_k = 0; m_ps = 0; m_ph = 0; m_po = 0;
    endtask

    task automatic model_sof();
        case (m_state)
            0: if (m_ps) begin m_state = 1; m_k = 0; end
            1: begin
                if (m_po)      begin m_state = 3; m_k = 0; end
                else if (m_ph) begin m_state = 2; m_k = 0; end
            end
            2: begin
                if (m_po) begin m_state = 3; m_k = 0; end
                else begin
                    m_k++;
                    if (m_k == BF) begin m_state = 1; m_k = 0; end
                end
            end
            3: begin
                m_k++;
                if (m_k == 8 * FS) begin m_state = 4; m_k = 0; end
            end
            4: if (m_ps) begin m_state = 0; m_k = 0; end
            default: m_state = 0;
        endcase
    endtask

    task automatic step(input bit sof, input bit gs, input bit ph, input bit go);
        @(negedge clk);
        bus.startOfFrame = sof;
        bus.gameStart    = gs;
        bus.playerHit    = ph;
        bus.gameOver     = go;
        if (sof) begin
            model_sof();
            m_ps = gs; m_ph = ph; m_po = go;
        end else begin
            m_ps |= gs; m_ph |= ph; m_po |= go;
        end
        @(posedge clk);
        #1;
        bus.startOfFrame = 1'b0;
        bus.gameStart    = 1'b0;
        bus.playerHit    = 1'b0;
        bus.gameOver     = 1'b0;
    endtask

    // One frame: events on the first idle cycle, SOF on the last of 'gap' cycles.
    task automatic frame(input int gap, input bit gs, input bit ph, input bit go);
        step(1'b0, gs, ph, go);
        repeat (gap - 2) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.startOfFrame = 1'b0;
        bus.gameStart    = 1'b0;
        bus.playerHit    = 1'b0;
        bus.gameOver     = 1'b0;
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (obs() !== RESET_OUT) begin
            n_fail++;
            $display("FAIL reset_values got %h want %h", obs(), RESET_OUT);
        end
    endtask

    task automatic test_start();
        do_reset();
        for (int c = 0; c <= 100; c++) begin
            step(c == 100, c == 10, 1'b0, 1'b0);
            n_tests++;
            if (obs() !== exp_out()) begin
                n_fail++;
                $display("FAIL start_cycle%0d got %h want %h", c, obs(), exp_out());
            end
        end
        n_tests++;
        if (bus.fxState !== 3'd1 || bus.layerEn !== 8'hFF) begin
            n_fail++;
            $display("FAIL start_play got state %0d mask %h want 1 ff", bus.fxState, bus.layerEn);
        end
    endtask

    task automatic test_blink();
        frame($urandom_range(2, 5), 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (obs() !== exp_out() || bus.fxState !== 3'd2 || bus.hitInvuln !== 1'b1 || bus.layerEn !== 8'hBF) begin
            n_fail++;
            $display("FAIL blink_entry got %h want %h", obs(), exp_out());
        end
        for (int i = 1; i <= BF; i++) begin
            frame($urandom_range(2, 5), 1'b0, i == 20, 1'b0);
            n_tests++;
            if (obs() !== exp_out()) begin
                n_fail++;
                $display("FAIL blink_frame%0d got %h want %h", i, obs(), exp_out());
            end
        end
        n_tests++;
        if (bus.fxState !== 3'd1 || bus.hitInvuln !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_exit got state %0d inv %b want 1 0", bus.fxState, bus.hitInvuln);
        end
    endtask

    task automatic test_blink_over();
        frame(3, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) frame($urandom_range(2, 4), 1'b0, 1'b0, 1'b0);
        frame(3, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (obs() !== exp_out() || bus.fxState !== 3'd3 || bus.fadeLevel !== 3'd0 || bus.hitInvuln !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_over got %h want state 3 fade 0 inv 0", obs());
        end
    endtask

    task automatic test_fade();
        for (int i = 1; i <= 8 * FS; i++) begin
            frame($urandom_range(2, 4), i == 10, 1'b0, 1'b0);
            n_tests++;
            if (obs() !== exp_out() || (i < 8 * FS && bus.fadeLevel !== 3'(i / FS))) begin
                n_fail++;
                $display("FAIL fade_frame%0d got %h want %h", i, obs(), exp_out());
            end
        end
        n_tests++;
        if (bus.fxState !== 3'd4 || bus.layerEn !== 8'h80 || bus.fadeLevel !== 3'd0) begin
            n_fail++;
            $display("FAIL fade_to_over got %h want state 4 mask 80 fade 0", obs());
        end
        frame(3, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.fxState !== 3'd0 || bus.layerEn !== 8'h81) begin
            n_fail++;
            $display("FAIL over_to_title got %h want state 0 mask 81", obs());
        end
    endtask

    task automatic test_sof_coincident();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.fxState !== 3'd0) begin
            n_fail++;
            $display("FAIL coincident_hold got state %0d want 0", bus.fxState);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (bus.fxState !== 3'd1 || obs() !== exp_out()) begin
            n_fail++;
            $display("FAIL coincident_next got state %0d want 1", bus.fxState);
        end
    endtask

    task automatic test_async_reset();
        frame(3, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5 * FS; i++) frame($urandom_range(2, 4), 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (bus.fadeLevel !== 3'd5 || bus.fxState !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_fade got fade %0d state %0d want 5 3", bus.fadeLevel, bus.fxState);
        end
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        n_tests++;
        if (obs() !== RESET_OUT) begin
            n_fail++;
            $display("FAIL async_reset got %h want %h", obs(), RESET_OUT);
        end
        repeat (2) @(negedge clk);
        model_reset();
        resetN = 1'b1;
        frame(3, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.fxState !== 3'd1 || obs() !== exp_out()) begin
            n_fail++;
            $display("FAIL post_reset_sof got state %0d want 1", bus.fxState);
        end
    endtask

    task automatic test_random();
        int gap;
        bit sof;
        do_reset();
        gap = $urandom_range(2, 6);
        for (int c = 0; c < 3000; c++) begin
            gap--;
            sof = (gap == 0);
            if (sof) gap = $urandom_range(2, 6);
            step(sof, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
            n_tests++;
            if (obs() !== exp_out()) begin
                n_fail++;
                $display("FAIL random_cycle%0d got %h want %h", c, obs(), exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_blink();
        test_blink_over();
        test_fade();
        test_sof_coincident();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
